// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with write bypass and a streaming dump sequencer
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1,
    parameter bit BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     dump_req,
    output logic                     dump_busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_idx,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic                we;
    logic [ADDR_W-1:0]   load_idx, idx_n;
    logic [DATA_W-1:0]   load_val, data_n;

    // writes to the hardwired zero register are dropped here, so bypass and dump capture never see them
    assign we = wr_en && !(ZERO_REG && wr_addr == '0);

    // register array: cleared on reset, one write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[p*ADDR_W +: ADDR_W];
        assign rd_data[p*DATA_W +: DATA_W] = (ZERO_REG && a == '0) ? '0 :
                                             (BYPASS && we && wr_addr == a) ? wr_data : mem[a];
    end

    // the dump always captures the post-write value, independent of the read-port bypass setting
    assign load_idx = (state == SCAN) ? dump_idx + ADDR_W'(1) : '0;
    assign load_val = (ZERO_REG && load_idx == '0) ? '0 :
                      (we && wr_addr == load_idx) ? wr_data : mem[load_idx];

    // dump sequencer next-state and beat update
    always_comb begin
        state_n = state;
        idx_n   = dump_idx;
        data_n  = dump_data;
        unique case (state)
            IDLE: if (dump_req) begin
                state_n = SCAN;
                idx_n   = '0;
                data_n  = load_val;
            end
            SCAN: if (dump_ready) begin
                if (dump_idx == LAST) begin
                    state_n = DONE;
                end else begin
                    idx_n  = load_idx;
                    data_n = load_val;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // dump state and beat registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dump_idx  <= '0;
            dump_data <= '0;
        end else begin
            state     <= state_n;
            dump_idx  <= idx_n;
            dump_data <= data_n;
        end
    end

    assign dump_busy  = state != IDLE;
    assign dump_valid = state == SCAN;
    assign dump_done  = state == DONE;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp reads, bypass and register dump
module tb_regfile_mp;
    localparam int DW = 32, NR = 32, AW = 5, NRD = 2;

    logic              clk = 0, rst = 0;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD*DW-1:0] rd_data, nb_rd_data;
    logic              wr_en = 0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              dump_req = 0, dump_ready = 0;
    logic              dump_busy, dump_valid, dump_done;
    logic [AW-1:0]     dump_idx;
    logic [DW-1:0]     dump_data;
    logic              nb_busy, nb_valid, nb_done;
    logic [AW-1:0]     nb_idx;
    logic [DW-1:0]     nb_data;

    typedef struct {logic [AW-1:0] idx; logic [DW-1:0] data; bit last;} beat_t;

    beat_t         sb[$];
    int            tests = 0, fails = 0;
    bit            exp_done = 0;
    logic [DW-1:0] model [NR];

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
    );

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dump_req(dump_req), .dump_busy(nb_busy), .dump_valid(nb_valid), .dump_ready(dump_ready),
        .dump_idx(nb_idx), .dump_data(nb_data), .dump_done(nb_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_en = 1;
        wr_addr = AW'(a);
        wr_data = d;
        step();
        wr_en = 0;
        if (a != 0) model[a] = d;
    endtask

    task automatic push_dump();
        for (int i = 0; i < NR; i++) sb.push_back('{AW'(i), (i == 0) ? '0 : model[i], i == NR - 1});
    endtask

    task automatic wait_done(input bit toggle);
        bit seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            if (toggle) dump_ready = ~dump_ready;
            step();
            seen = dump_done;
        end
        chk("done_seen", DW'(seen), 1);
    endtask

    // monitor: compare each presented dump beat against the scoreboard head, pop on acceptance
    always @(negedge clk) begin
        if (!rst) begin
            chk("dump_done", DW'(dump_done), DW'(exp_done));
            exp_done = 0;
            if (dump_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got idx %0d data %h expected no beat", dump_idx, dump_data);
                end else begin
                    chk("dump_idx", DW'(dump_idx), DW'(sb[0].idx));
                    chk("dump_data", dump_data, sb[0].data);
                    if (dump_ready) begin
                        exp_done = sb[0].last;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NR; i++) model[i] = '0;
        #3 rst = 1;
        #1;
        chk("rst_valid", DW'(dump_valid), 0);
        chk("rst_busy", DW'(dump_busy), 0);
        chk("rst_done", DW'(dump_done), 0);
        chk("rst_data", dump_data, 0);
        chk("rst_idx", DW'(dump_idx), 0);
        repeat (2) step();
        rst = 0;
        for (int i = 0; i < NR; i++) begin
            rd(i, NR - 1 - i);
            chk("rst_rd0", rd_data[0 +: DW], 0);
            chk("rst_rd1", rd_data[DW +: DW], 0);
        end

        wr(5, 32'hDEADBEEF);
        rd(5, 5);
        chk("r5_p0", rd_data[0 +: DW], 32'hDEADBEEF);
        chk("r5_p1", rd_data[DW +: DW], 32'hDEADBEEF);
        wr(0, 32'h1234);
        rd(0, 0);
        chk("r0_p0", rd_data[0 +: DW], 0);
        chk("r0_p1", rd_data[DW +: DW], 0);

        wr(7, 32'h77);
        wr(8, 32'h88888888);
        rd(7, 8);
        wr_en = 1;
        wr_addr = 7;
        wr_data = 32'hA5A5A5A5;
        #1;
        chk("byp_p0", rd_data[0 +: DW], 32'hA5A5A5A5);
        chk("byp_p1", rd_data[DW +: DW], 32'h88888888);
        chk("nobyp_p0", nb_rd_data[0 +: DW], 32'h77);
        step();
        wr_en = 0;
        model[7] = 32'hA5A5A5A5;
        #1;
        chk("r7_after", rd_data[0 +: DW], 32'hA5A5A5A5);
        chk("nb_r7_after", nb_rd_data[0 +: DW], 32'hA5A5A5A5);

        for (int i = 1; i < NR; i++) wr(i, DW'(i * 'h11));
        push_dump();
        dump_ready = 0;
        dump_req = 1;
        step();
        dump_req = 0;
        chk("busy_on", DW'(dump_busy), 1);
        wait_done(1);
        step();
        chk("busy_off", DW'(dump_busy), 0);
        chk("sb_empty4", DW'(sb.size()), 0);

        dump_ready = 1;
        push_dump();
        sb[10].data = 32'hCAFE;
        dump_req = 1;
        step();
        dump_req = 0;
        begin
            bit seen = 0;
            for (int c = 0; c < 40 && !seen; c++) begin
                if (c == 4) begin
                    wr_en = 1;
                    wr_addr = 3;
                    wr_data = 32'hBEEF;
                end
                if (c == 9) begin
                    wr_en = 1;
                    wr_addr = 10;
                    wr_data = 32'hCAFE;
                end
                step();
                wr_en = 0;
                seen = dump_done;
            end
            chk("done_seen5", DW'(seen), 1);
        end
        model[3] = 32'hBEEF;
        model[10] = 32'hCAFE;
        step();
        rd(3, 10);
        chk("r3_read", rd_data[0 +: DW], 32'hBEEF);
        chk("r10_read", rd_data[DW +: DW], 32'hCAFE);
        chk("sb_empty5", DW'(sb.size()), 0);

        push_dump();
        dump_req = 1;
        step();
        dump_req = 0;
        repeat (12) step();
        #2 rst = 1;
        #1;
        chk("mid_valid", DW'(dump_valid), 0);
        chk("mid_busy", DW'(dump_busy), 0);
        chk("mid_done", DW'(dump_done), 0);
        chk("mid_data", dump_data, 0);
        sb.delete();
        step();
        rst = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        rd(5, 10);
        chk("clr_r5", rd_data[0 +: DW], 0);
        chk("clr_r10", rd_data[DW +: DW], 0);
        push_dump();
        dump_req = 1;
        step();
        dump_req = 0;
        wait_done(0);
        step();
        chk("sb_empty6", DW'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
